mmio_fifo_ctrl: RTL and testbench
=================================

Name: mmio_fifo_ctrl

Overview:
- MMIO-facing FIFO stage between the AFU MMIO address decoder and its user data path.
- Accepts decoded MMIO write strobes as pushes and decoded MMIO reads as pops or status queries.
- Returns a registered, TID-tagged read response that the AFU copies directly into its CCI-P c2 response.
- Replaces the fixed-latency shift buffer with a true circular FIFO that reports occupancy and sticky error flags.

Parameters:
- DATA_W, 64, width of each FIFO entry and of rsp_data.
- DEPTH, 8, number of entries; must be a power of 2, at least 2 and at most 4096.
- TID_W, 9, width of the CCI-P MMIO transaction ID.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wr_valid  in  1  push strobe: MMIO write to the data address
- wr_data  in  DATA_W  push data
- rd_req  in  1  MMIO read strobe for this block
- rd_sel  in  1  0 = data read (pops the FIFO), 1 = status read (no pop)
- rd_tid  in  TID_W  TID of the MMIO read
- flush  in  1  discards all entries
- clr_sticky  in  1  clears the overflow and underflow flags
- rsp_valid  out  1  read response valid, 1-cycle pulse
- rsp_tid  out  TID_W  echoed rd_tid
- rsp_data  out  DATA_W  response data
- count  out  log2(DEPTH)+1  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a data read was made while empty

Behaviour:
- Reset values:
  - Pointers, count, overflow, underflow, rsp_valid, rsp_tid and rsp_data reset to 0.
  - empty resets to 1 and full resets to 0.
  - Storage contents are not reset.
- Reset asserted mid-operation discards all contents and any pending response; no response is issued for a read accepted in the cycle reset asserts.
- Storage is a circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits each. Pointers wrap naturally from DEPTH-1 to 0.
- count is a separate log2(DEPTH)+1-bit counter. full and empty are decoded combinationally from the registered count.
- Push: when wr_valid is 1 and full is 0, write mem[wr_ptr] = wr_data, increment wr_ptr, and increment count.
- Dropped push: when wr_valid is 1 and full is 1, the data is dropped and overflow is set to 1. The exception is a push with a simultaneous pop (see below).
- Data read (rd_req=1, rd_sel=0), latency 1 cycle:
  - Next cycle rsp_valid=1, rsp_tid=rd_tid and rsp_data=mem[rd_ptr].
  - rd_ptr increments and count decrements.
- Data read while empty: rsp_valid=1, rsp_data=0 and underflow is set to 1. Pointers and count are unchanged.
- Status read (rd_req=1, rd_sel=1), latency 1 cycle:
  - rsp_data[15:0] = count, zero-extended.
  - rsp_data[28] = empty, rsp_data[29] = full, rsp_data[30] = underflow, rsp_data[31] = overflow.
  - All other bits are 0.
  - The values reported are the pre-cycle register values.
- rsp_valid deasserts in every cycle following a cycle with no rd_req.
- Simultaneous push and pop when neither full nor empty: both occur and count is unchanged.
- Push and pop when full: the pop frees a slot, so the push is accepted, count stays at DEPTH and overflow is not set.
- Push and pop when empty: the pop underflows and returns 0, and the push is accepted, giving count=1. There is no write-to-read bypass.
- flush:
  - Has priority over push and pop in the same cycle: pointers and count go to 0 and the concurrent push is discarded.
  - A concurrent rd_req still responds. A data read returns 0 and does not set underflow; a status read returns pre-flush values.
  - Sticky flags are unaffected.
- clr_sticky clears both flags. If a set event occurs in the same cycle, the set wins.
- Error flags clear only on reset or clr_sticky.

Decomposition:
- Shared package afu_fifo_pkg holds:
  - rd_sel encodings RD_SEL_DATA=0 and RD_SEL_STATUS=1;
  - status bit positions STAT_EMPTY=28, STAT_FULL=29, STAT_UNDERFLOW=30, STAT_OVERFLOW=31;
  - STAT_COUNT_LSB=0 and STAT_COUNT_W=16;
  - the MMIO data/status addresses 16'h0020 and 16'h0022 used by the decoder.
- One sub-module, fifo_ram: DEPTH x DATA_W storage with a synchronous write port and an asynchronous read port, no reset. mmio_fifo_ctrl owns all pointers, counters and flags.

Test Plan:
- Reset, then status read with tid=9'h05 -> next cycle rsp_valid=1, rsp_tid=9'h05, rsp_data=64'h0000_0000_1000_0000 (empty=1, count=0).
- Push 64'hA, 64'hB, 64'hC, then 3 data reads -> responses return A, B, C in order, each 1 cycle after its rd_req; count ends at 0 and empty=1.
- Push 9 values 1..9 with DEPTH=8 -> count=8, full=1, value 9 dropped, overflow=1. A status read returns rsp_data[31]=1, [29]=1 and [15:0]=8. Draining returns 1..8.
- With the FIFO full, push 64'h55 in the same cycle as a data read -> the read returns the oldest entry, count stays 8, and overflow stays 0. Draining the last entry returns 64'h55.
- Data read on an empty FIFO -> rsp_data=0 and underflow=1. Pulsing clr_sticky then reading status gives bit 30 = 0.
- Push 12 values through DEPTH=8 with interleaved reads (pointer wrap), then assert rst mid-stream -> output order is preserved across the wrap, and after reset count=0, empty=1 and no rsp_valid pulse for the read in the reset cycle.

Source files
------------

// File: rtl/afu_fifo_pkg.sv
// Shared encodings for the AFU MMIO FIFO: read-select codes, status word layout and
// decoder addresses.
package afu_fifo_pkg;

  localparam logic RD_SEL_DATA   = 1'b0;
  localparam logic RD_SEL_STATUS = 1'b1;

  localparam int unsigned STAT_COUNT_LSB = 0;
  localparam int unsigned STAT_COUNT_W   = 16;
  localparam int unsigned STAT_EMPTY     = 28;
  localparam int unsigned STAT_FULL      = 29;
  localparam int unsigned STAT_UNDERFLOW = 30;
  localparam int unsigned STAT_OVERFLOW  = 31;

  localparam logic [15:0] MMIO_ADDR_DATA   = 16'h0020;
  localparam logic [15:0] MMIO_ADDR_STATUS = 16'h0022;

  function automatic logic [31:0] status_word(input logic [STAT_COUNT_W-1:0] cnt,
                                              input logic emp, input logic ful,
                                              input logic udf, input logic ovf);
    logic [31:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = cnt;
    s[STAT_EMPTY]     = emp;
    s[STAT_FULL]      = ful;
    s[STAT_UNDERFLOW] = udf;
    s[STAT_OVERFLOW]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, contents never reset.
module fifo_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-facing circular FIFO: pushes from MMIO writes, pops/status from MMIO reads,
// registered TID-tagged response, occupancy and sticky error flags.
module mmio_fifo_ctrl
  import afu_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TID_W  = 9,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic              rd_sel,
  input  logic [TID_W-1:0]  rd_tid,
  input  logic              flush,
  input  logic              clr_sticky,
  output logic              rsp_valid,
  output logic [TID_W-1:0]  rsp_tid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rsp_valid_q;
  logic [TID_W-1:0]  rsp_tid_q, rsp_tid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d, ram_rdata;
  logic              pop_req, pop_ok, push_ok, ovf_ev, udf_ev;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    pop_req = rd_req && (rd_sel == RD_SEL_DATA) && !flush;
    pop_ok  = pop_req && !empty;
    udf_ev  = pop_req && empty;
    // A pop in the same cycle frees a slot, so a push against a full FIFO is not dropped.
    push_ok = wr_valid && !flush && (!full || pop_ok);
    ovf_ev  = wr_valid && !flush && full && !pop_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end

    ovf_d = (ovf_q && !clr_sticky) || ovf_ev;
    udf_d = (udf_q && !clr_sticky) || udf_ev;

    rsp_tid_d  = rsp_tid_q;
    rsp_data_d = rsp_data_q;
    if (rd_req) begin
      rsp_tid_d = rd_tid;
      if (rd_sel == RD_SEL_STATUS) begin
        rsp_data_d = DATA_W'(status_word(STAT_COUNT_W'(count_q), empty, full, udf_q, ovf_q));
      end else if (flush || empty) begin
        rsp_data_d = '0;
      end else begin
        rsp_data_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      rsp_valid_q <= rd_req;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tid   = rsp_tid_q;
  assign rsp_data  = rsp_data_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Directed-vector bench for mmio_fifo_ctrl (DEPTH=8): ordering, overflow, full push/pop,
// underflow, flush, pointer wrap and mid-stream reset.
module tb_mmio_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [63:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic        rd_sel = 1'b0;
  logic [8:0]  rd_tid = '0;
  logic        flush = 1'b0;
  logic        clr_sticky = 1'b0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic [3:0]  count;
  logic        full, empty, overflow, underflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  mmio_fifo_ctrl #(
    .DATA_W (64),
    .DEPTH  (8),
    .TID_W  (9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_tid     (rd_tid),
    .flush      (flush),
    .clr_sticky (clr_sticky),
    .rsp_valid  (rsp_valid),
    .rsp_tid    (rsp_tid),
    .rsp_data   (rsp_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // One clock with the given strobes; returns #1 after the edge with strobes cleared.
  task automatic cyc(input logic w, input logic [63:0] d, input logic r, input logic s,
                     input logic [8:0] t, input logic f, input logic c);
    wr_valid = w; wr_data = d; rd_req = r; rd_sel = s; rd_tid = t;
    flush = f; clr_sticky = c;
    @(posedge clk);
    #1;
    wr_valid = 1'b0; rd_req = 1'b0; flush = 1'b0; clr_sticky = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vec_cnt++;
    if ({rsp_valid, count, full, empty, overflow, underflow} !== {1'b0, 4'd0, 1'b0, 1'b1, 2'b00}) begin
      err_cnt++;
      $display("FAIL reset_state: got v=%b cnt=%0d f=%b e=%b o=%b u=%b, want v=0 cnt=0 f=0 e=1 o=0 u=0",
               rsp_valid, count, full, empty, overflow, underflow);
    end
    vec_cnt++;
    if (rsp_data !== 64'h0 || rsp_tid !== 9'h0) begin
      err_cnt++;
      $display("FAIL reset_rsp: got data=%h tid=%h, want 0/0", rsp_data, rsp_tid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, '0, 1'b1, 1'b1, 9'h05, 1'b0, 1'b0);
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h05 || rsp_data !== 64'h0000_0000_1000_0000) begin
      err_cnt++;
      $display("FAIL reset_status: got v=%b tid=%h data=%h, want v=1 tid=005 data=0000000010000000",
               rsp_valid, rsp_tid, rsp_data);
    end
  endtask

  task automatic test_order();
    logic [63:0] exp_vals [3];
    exp_vals[0] = 64'hA; exp_vals[1] = 64'hB; exp_vals[2] = 64'hC;
    for (int i = 0; i < 3; i++) cyc(1'b1, exp_vals[i], 1'b0, 1'b0, '0, 1'b0, 1'b0);
    vec_cnt++;
    if (count !== 4'd3 || rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL order_fill: got cnt=%0d v=%b, want cnt=3 v=0", count, rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 9'(9'h10 + i), 1'b0, 1'b0);
      vec_cnt++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_vals[i] || rsp_tid !== 9'(9'h10 + i)) begin
        err_cnt++;
        $display("FAIL order_read%0d: got v=%b data=%h tid=%h, want v=1 data=%h tid=%h",
                 i, rsp_valid, rsp_data, rsp_tid, exp_vals[i], 9'(9'h10 + i));
      end
    end
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    vec_cnt++;
    if (count !== 4'd0 || empty !== 1'b1 || rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL order_end: got cnt=%0d e=%b v=%b, want cnt=0 e=1 v=0", count, empty, rsp_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) cyc(1'b1, 64'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    vec_cnt++;
    if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL ovf_flags: got cnt=%0d f=%b o=%b u=%b, want cnt=8 f=1 o=1 u=0",
               count, full, overflow, underflow);
    end
    cyc(1'b0, '0, 1'b1, 1'b1, 9'h07, 1'b0, 1'b0);
    vec_cnt++;
    if (rsp_data !== 64'h0000_0000_A000_0008) begin
      err_cnt++;
      $display("FAIL ovf_status: got %h, want 00000000a0000008", rsp_data);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 9'h08, 1'b0, 1'b0);
      vec_cnt++;
      if (rsp_valid !== 1'b1 || rsp_data !== 64'(i)) begin
        err_cnt++;
        $display("FAIL ovf_drain%0d: got v=%b data=%h, want v=1 data=%h", i, rsp_valid, rsp_data, 64'(i));
      end
    end
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    vec_cnt++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_clear: got o=%b u=%b e=%b, want o=0 u=0 e=1", overflow, underflow, empty);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'(16 + i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 64'h55, 1'b1, 1'b0, 9'h0A, 1'b0, 1'b0);
    vec_cnt++;
    if (rsp_data !== 64'h10 || count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
      err_cnt++;
      $display("FAIL full_pushpop: got data=%h cnt=%0d o=%b f=%b, want data=10 cnt=8 o=0 f=1",
               rsp_data, count, overflow, full);
    end
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 9'h0B, 1'b0, 1'b0);
      vec_cnt++;
      if (rsp_data !== 64'(16 + i)) begin
        err_cnt++;
        $display("FAIL full_drain%0d: got %h, want %h", i, rsp_data, 64'(16 + i));
      end
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 9'h0C, 1'b0, 1'b0);
    vec_cnt++;
    if (rsp_data !== 64'h55 || empty !== 1'b1) begin
      err_cnt++;
      $display("FAIL full_last: got data=%h e=%b, want data=55 e=1", rsp_data, empty);
    end
  endtask

  task automatic test_underflow();
    cyc(1'b0, '0, 1'b1, 1'b0, 9'h1F0, 1'b0, 1'b0);
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h1F0 || rsp_data !== 64'h0 || underflow !== 1'b1 ||
        count !== 4'd0) begin
      err_cnt++;
      $display("FAIL udf_read: got v=%b tid=%h data=%h u=%b cnt=%0d, want v=1 tid=1f0 data=0 u=1 cnt=0",
               rsp_valid, rsp_tid, rsp_data, underflow, count);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1, 9'h02, 1'b0, 1'b0);
    vec_cnt++;
    if (rsp_data !== 64'h0000_0000_1000_0000 || underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL udf_clear_status: got data=%h u=%b, want data=0000000010000000 u=0",
               rsp_data, underflow);
    end
    // Push and pop on empty: pop underflows, push lands.
    cyc(1'b1, 64'hAB, 1'b1, 1'b0, 9'h03, 1'b0, 1'b0);
    vec_cnt++;
    if (rsp_data !== 64'h0 || count !== 4'd1 || underflow !== 1'b1) begin
      err_cnt++;
      $display("FAIL udf_pushpop_empty: got data=%h cnt=%0d u=%b, want data=0 cnt=1 u=1",
               rsp_data, count, underflow);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 9'h04, 1'b0, 1'b1);
    vec_cnt++;
    if (rsp_data !== 64'hAB || count !== 4'd0 || underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL udf_pop_clr: got data=%h cnt=%0d u=%b, want data=ab cnt=0 u=0",
               rsp_data, count, underflow);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 9'h05, 1'b0, 1'b1);
    vec_cnt++;
    if (underflow !== 1'b1) begin
      err_cnt++;
      $display("FAIL udf_set_wins: got u=%b, want u=1", underflow);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'(32 + i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 64'h77, 1'b1, 1'b0, 9'h06, 1'b1, 1'b0);
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'h0 || count !== 4'd0 || empty !== 1'b1 ||
        underflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_data: got v=%b data=%h cnt=%0d e=%b u=%b, want v=1 data=0 cnt=0 e=1 u=0",
               rsp_valid, rsp_data, count, empty, underflow);
    end
    cyc(1'b1, 64'h99, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1, 9'h07, 1'b1, 1'b0);
    vec_cnt++;
    if (rsp_data !== 64'h1 || count !== 4'd0) begin
      err_cnt++;
      $display("FAIL flush_status: got data=%h cnt=%0d, want data=1 cnt=0", rsp_data, count);
    end
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 64'(256 + i), (i >= 4), 1'b0, 9'h0D, 1'b0, 1'b0);
      if (i >= 4) begin
        vec_cnt++;
        if (rsp_data !== 64'(256 + i - 4) || count !== 4'd4) begin
          err_cnt++;
          $display("FAIL wrap_read%0d: got data=%h cnt=%0d, want data=%h cnt=4",
                   i, rsp_data, count, 64'(256 + i - 4));
        end
      end
    end
    rd_req = 1'b1; rd_sel = 1'b0; rd_tid = 9'h0E; rst = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    vec_cnt++;
    if (rsp_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      err_cnt++;
      $display("FAIL wrap_reset: got v=%b cnt=%0d e=%b f=%b, want v=0 cnt=0 e=1 f=0",
               rsp_valid, count, empty, full);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, '0, 1'b1, 1'b1, 9'h0F, 1'b0, 1'b0);
    vec_cnt++;
    if (rsp_data !== 64'h0000_0000_1000_0000 || rsp_tid !== 9'h0F) begin
      err_cnt++;
      $display("FAIL wrap_post_status: got data=%h tid=%h, want 0000000010000000/00f", rsp_data, rsp_tid);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_flush();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
